ring_burst_scheduler: RTL and testbench

//  Drains the DDR ring buffer's ingress FIFO (async-read configuration, OPT_ASYNC_READ=1) into DDR write bursts.

---
 rtl/ring_burst_scheduler.sv | 89 ++++++++
 tb/tb_ring_burst_scheduler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_burst_scheduler.sv
// ring_burst_scheduler: drains an async-read FIFO into DDR write bursts on a wrapping ring buffer
module ring_burst_scheduler #(
  parameter int BW      = 8,
  parameter int LGFLEN  = 4,
  parameter int LGBURST = 2,
  parameter int AW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_enable,
  input  logic              i_flush,
  input  logic [AW-1:0]     i_base,
  input  logic [AW-1:0]     i_limit,
  input  logic [LGFLEN:0]   i_fifo_fill,
  input  logic              i_fifo_empty,
  input  logic [BW-1:0]     i_fifo_data,
  output logic              o_fifo_rd,
  output logic              o_cmd_valid,
  input  logic              i_cmd_ready,
  output logic [AW-1:0]     o_cmd_addr,
  output logic [LGBURST:0]  o_cmd_len,
  output logic              o_wvalid,
  input  logic              i_wready,
  output logic [BW-1:0]     o_wdata,
  output logic              o_wlast,
  output logic [AW-1:0]     o_wr_ofs,
  output logic              o_wrapped,
  output logic              o_busy
);
  localparam int BURST_LEN = 1 << LGBURST;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LGFLEN:0] BL_FILL = BURST_LEN[LGFLEN:0];
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer;
  logic [AW-1:0] ofs, limit_q, ofs_eff, room, want, len_w, ofs_end;
  logic [LGBURST:0] count;
  logic full, partial, start, beat, last;
  assign ofs_eff = (ofs >= i_limit) ? '0 : ofs;
  assign room = i_limit - ofs_eff;
  assign full = i_fifo_fill >= BL_FILL;
  assign partial = !i_fifo_empty && i_fifo_fill != '0 && (timer >= TW'(TIMEOUT) || i_flush);
  assign want = full ? AW'(BURST_LEN) : AW'(i_fifo_fill);
  // a burst never crosses the ring end, so clip to the words left before it
  assign len_w = (room < want) ? room : want;
  assign start = state == IDLE && i_enable && i_limit != '0 && (full || partial);
  assign beat = state == DATA && i_wready;
  assign last = beat && count == (LGBURST+1)'(1);
  assign ofs_end = ofs + AW'(o_cmd_len);
  assign o_cmd_valid = state == CMD;
  assign o_wvalid = state == DATA;
  assign o_wlast = o_wvalid && count == (LGBURST+1)'(1);
  assign o_fifo_rd = beat;
  assign o_wdata = i_fifo_data;
  assign o_wr_ofs = ofs;
  assign o_busy = state != IDLE;
  always_comb begin
    state_n = start ? CMD : (state == CMD && i_cmd_ready) ? DATA : last ? IDLE : state;
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      timer <= '0;
      ofs <= '0;
      limit_q <= '0;
      count <= '0;
      o_cmd_addr <= '0;
      o_cmd_len <= '0;
      o_wrapped <= 1'b0;
    end else begin
      o_wrapped <= last && ofs_end == limit_q;
      if (start) begin
        timer <= '0;
        ofs <= ofs_eff;
        limit_q <= i_limit;
        o_cmd_addr <= i_base + ofs_eff;
        o_cmd_len <= len_w[LGBURST:0];
      end else if (state == IDLE)
        timer <= (i_fifo_fill == '0) ? '0 : (!full && timer < TW'(TIMEOUT)) ? timer + 1'b1 : timer;
      if (state == CMD && i_cmd_ready) count <= o_cmd_len;
      else if (beat) count <= count - 1'b1;
      if (last) ofs <= (ofs_end == limit_q) ? '0 : ofs_end;
    end
  end
endmodule

// File: tb/tb_ring_burst_scheduler.sv
// tb_ring_burst_scheduler: FIFO model plus data scoreboard around ring_burst_scheduler
module tb_ring_burst_scheduler;
  logic clk = 0, rst_n = 0, enable = 0, flush = 0, cmd_ready = 1, wready = 1;
  logic [15:0] base = 0, limit = 0;
  logic [4:0] fifo_fill = 0;
  logic fifo_empty = 1;
  logic [7:0] fifo_data = 0;
  logic o_fifo_rd, o_cmd_valid, o_wvalid, o_wlast, o_wrapped, o_busy;
  logic [15:0] o_cmd_addr, o_wr_ofs;
  logic [2:0] o_cmd_len;
  logic [7:0] o_wdata;

  ring_burst_scheduler dut (
    .i_clk(clk), .i_rstn(rst_n), .i_enable(enable), .i_flush(flush),
    .i_base(base), .i_limit(limit), .i_fifo_fill(fifo_fill), .i_fifo_empty(fifo_empty),
    .i_fifo_data(fifo_data), .o_fifo_rd(o_fifo_rd), .o_cmd_valid(o_cmd_valid),
    .i_cmd_ready(cmd_ready), .o_cmd_addr(o_cmd_addr), .o_cmd_len(o_cmd_len),
    .o_wvalid(o_wvalid), .i_wready(wready), .o_wdata(o_wdata), .o_wlast(o_wlast),
    .o_wr_ofs(o_wr_ofs), .o_wrapped(o_wrapped), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] base, limit;
    int nw;
    bit fl;
    logic [15:0] addr;
    int len;
    logic [15:0] ofs;
    int wrap;
  } vec_t;
  vec_t tbl[9];

  int checks = 0, failures = 0;
  int n_cmd = 0, n_beats = 0, n_rd = 0, n_wrap = 0, bl = 0;
  logic [15:0] last_addr = 0, pa = 0;
  int last_len = 0;
  logic [2:0] pl = 0;
  logic [7:0] pd = 0, wcnt = 0;
  logic [8:0] ed;
  bit pcv = 0, pcr = 0, pwv = 0, pwr = 0, rd_s = 0, rnd = 0;
  logic [7:0] fq[$], pq[$], exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      pq.push_back(wcnt);
      exp_q.push_back(wcnt);
      wcnt++;
    end
    tick();
  endtask

  task automatic wait_cmd(input int c0);
    int n = 0;
    while (n_cmd == c0 && n < 300) begin tick(); n++; end
    chk("cmd_seen", n_cmd != c0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 500) begin tick(); n++; end
    chk("idle_reached", o_busy, 0);
  endtask

  // async-read FIFO model: pops on the rd seen before the edge, then accepts pending writes
  always @(posedge clk) begin
    if (rd_s && fq.size() != 0) fq.delete(0);
    while (pq.size() != 0 && fq.size() < 16) fq.push_back(pq.pop_front());
    fifo_fill <= 5'(fq.size());
    fifo_empty <= fq.size() == 0;
    fifo_data <= fq.size() != 0 ? fq[0] : 8'h0;
  end

  always @(posedge clk) if (rnd) begin
    #1;
    cmd_ready = $urandom_range(0, 1);
    wready = $urandom_range(0, 3) != 0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      pcv = 0; pwv = 0; bl = 0; rd_s = 0;
    end else begin
      rd_s = o_fifo_rd;
      if (pcv && !pcr) begin
        chk("cmd_hold_valid", o_cmd_valid, 1);
        chk("cmd_hold_addr", o_cmd_addr, pa);
        chk("cmd_hold_len", o_cmd_len, pl);
      end
      if (pwv && !pwr) begin
        chk("w_hold_valid", o_wvalid, 1);
        chk("w_hold_data", o_wdata, pd);
      end
      if (o_wvalid || o_fifo_rd) chk("fifo_rd", o_fifo_rd, o_wvalid && wready);
      if (o_fifo_rd) n_rd++;
      if (o_cmd_valid && cmd_ready) begin
        n_cmd++;
        last_addr = o_cmd_addr;
        last_len = o_cmd_len;
        bl = o_cmd_len;
      end
      if (o_wvalid && wready) begin
        n_beats++;
        chk("wlast", o_wlast, bl == 1);
        ed = exp_q.size() != 0 ? {1'b0, exp_q.pop_front()} : 9'h100;
        chk("sb_data", {1'b0, o_wdata}, ed);
        if (bl > 0) bl--;
      end
      if (o_wrapped) n_wrap++;
      pcv = o_cmd_valid; pcr = cmd_ready; pa = o_cmd_addr; pl = o_cmd_len;
      pwv = o_wvalid; pwr = wready; pd = o_wdata;
    end
  end

  initial begin
    int n, m, c0, w0, b0, r0, sent, it, k;
    tbl[0] = '{16'h0100, 16, 3, 1, 16'h0104, 3, 7, 0};
    tbl[1] = '{16'h0100, 16, 4, 0, 16'h0107, 4, 11, 0};
    tbl[2] = '{16'h0100, 8, 2, 1, 16'h0100, 2, 2, 0};
    tbl[3] = '{16'h0100, 8, 4, 0, 16'h0102, 4, 6, 0};
    tbl[4] = '{16'h0100, 8, 4, 0, 16'h0106, 2, 0, 1};
    tbl[5] = '{16'h0100, 8, 2, 0, 16'h0100, 4, 4, 0};
    tbl[6] = '{16'hFFFE, 16, 4, 0, 16'h0002, 4, 8, 0};
    tbl[7] = '{16'h0200, 12, 4, 0, 16'h0208, 4, 0, 1};
    tbl[8] = '{16'h0200, 12, 1, 1, 16'h0200, 1, 1, 0};
    base = 16'h0100; limit = 16; enable = 1;
    repeat (3) tick();
    chk("rst_cmd_valid", o_cmd_valid, 0);
    chk("rst_wvalid", o_wvalid, 0);
    chk("rst_fifo_rd", o_fifo_rd, 0);
    chk("rst_wlast", o_wlast, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_wrapped", o_wrapped, 0);
    chk("rst_ofs", o_wr_ofs, 0);
    chk("rst_cmd_addr", o_cmd_addr, 0);
    chk("rst_cmd_len", o_cmd_len, 0);
    rst_n = 1;
    tick();
    // full burst: latency to command and to first beat
    c0 = n_cmd; b0 = n_beats; r0 = n_rd;
    push(4);
    n = 0;
    while (!o_cmd_valid && n < 50) begin tick(); n++; end
    chk("full_cmd_latency", n, 1);
    m = 0;
    while (!o_wvalid && m < 50) begin tick(); m++; end
    chk("first_beat_latency", m, 1);
    wait_idle(); tick();
    chk("full_addr", last_addr, 16'h0100);
    chk("full_len", last_len, 4);
    chk("full_ofs", o_wr_ofs, 4);
    chk("full_beats", n_beats - b0, 4);
    chk("full_rd", n_rd - r0, 4);
    for (int r = 0; r < 9; r++) begin
      c0 = n_cmd; w0 = n_wrap;
      base = tbl[r].base; limit = tbl[r].limit; flush = tbl[r].fl;
      push(tbl[r].nw);
      wait_cmd(c0);
      flush = 0;
      wait_idle(); tick();
      chk($sformatf("row%0d_addr", r), last_addr, tbl[r].addr);
      chk($sformatf("row%0d_len", r), last_len, tbl[r].len);
      chk($sformatf("row%0d_ofs", r), o_wr_ofs, tbl[r].ofs);
      chk($sformatf("row%0d_wrap", r), n_wrap - w0, tbl[r].wrap);
    end
    // partial burst forced by idle timeout
    base = 16'h0100; limit = 16;
    push(2);
    n = 0;
    while (!o_cmd_valid && n < 200) begin tick(); n++; end
    chk("timeout_latency", n, 65);
    chk("timeout_len", o_cmd_len, 2);
    chk("timeout_addr", o_cmd_addr, 16'h0101);
    wait_idle(); tick();
    chk("timeout_ofs", o_wr_ofs, 3);
    flush = 1;
    push(2);
    n = 0;
    while (!o_cmd_valid && n < 200) begin tick(); n++; end
    chk("flush_latency", n, 1);
    chk("flush_len", o_cmd_len, 2);
    wait_idle(); tick();
    flush = 0;
    chk("flush_ofs", o_wr_ofs, 5);
    // random backpressure over 200 words
    base = 16'h0000; limit = 16; rnd = 1;
    sent = 0; it = 0;
    while (sent < 200 && it < 20000) begin
      it++;
      if (fq.size() + pq.size() <= 12) begin
        k = $urandom_range(1, 4);
        if (k > 200 - sent) k = 200 - sent;
        push(k);
        sent += k;
      end else tick();
    end
    flush = 1;
    n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < 3000) begin tick(); n++; end
    chk("rnd_sent", sent, 200);
    chk("rnd_drain", exp_q.size(), 0);
    flush = 0; rnd = 0;
    tick(); tick();
    cmd_ready = 1; wready = 0;
    // asynchronous reset in the middle of a data phase
    base = 16'h0300; limit = 16;
    push(4);
    n = 0;
    while (!o_wvalid && n < 50) begin tick(); n++; end
    chk("rst_pre_wvalid", o_wvalid, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_cmd_valid", o_cmd_valid, 0);
    chk("arst_wvalid", o_wvalid, 0);
    chk("arst_fifo_rd", o_fifo_rd, 0);
    chk("arst_wlast", o_wlast, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_wrapped", o_wrapped, 0);
    chk("arst_ofs", o_wr_ofs, 0);
    chk("arst_cmd_addr", o_cmd_addr, 0);
    chk("arst_cmd_len", o_cmd_len, 0);
    @(negedge clk);
    tick();
    rst_n = 1; wready = 1;
    c0 = n_cmd;
    wait_cmd(c0);
    chk("post_rst_addr", last_addr, 16'h0300);
    chk("post_rst_len", last_len, 4);
    wait_idle(); tick();
    chk("post_rst_ofs", o_wr_ofs, 4);
    chk("post_rst_sb", exp_q.size(), 0);
    // enable dropped during beat 2 of 4
    c0 = n_cmd; b0 = n_beats;
    push(8);
    n = 0;
    while (n_beats < b0 + 1 && n < 100) begin tick(); n++; end
    enable = 0;
    wait_idle(); tick();
    chk("en_drop_beats", n_beats - b0, 4);
    chk("en_drop_len", last_len, 4);
    repeat (20) tick();
    chk("en_drop_cmds", n_cmd - c0, 1);
    chk("en_drop_busy", o_busy, 0);
    chk("en_drop_fill", fifo_fill, 4);
    enable = 1;
    wait_cmd(c0 + 1);
    wait_idle(); tick();
    chk("en_resume_beats", n_beats - b0, 8);
    chk("en_resume_ofs", o_wr_ofs, 12);
    chk("en_resume_sb", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
